// File: rtl/shift_pipe.sv
// shift_pipe: SHW-stage barrel shift pipeline with valid/ready flow; rotate gated by SHIFT_PIPE_ROTATE_EN
module shift_pipe #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_mode,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
`ifdef SHIFT_PIPE_ROTATE_EN
  localparam logic SQUASH_ROR = 1'b0;
`else
  localparam logic SQUASH_ROR = 1'b1;
`endif
  typedef struct packed {
    logic             vld;
    logic             en;
    logic [1:0]       mode;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] data;
  } stage_t;
  stage_t st_q [SHW];
  stage_t st_d [SHW];
  stage_t in_st, cur;
  logic advance;
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] x, input logic [1:0] m, input int s);
    logic [WIDTH-1:0] rot;
    rot = SQUASH_ROR ? x : (x >> s) | (x << (WIDTH - s));
    return m == 2'b00 ? x >> s : m == 2'b01 ? x << s : m == 2'b10 ? WIDTH'($signed(x) >>> s) : rot;
  endfunction
  assign advance   = !st_q[SHW-1].vld || out_ready;
  assign in_ready  = advance;
  assign out_valid = st_q[SHW-1].vld;
  assign out_data  = st_q[SHW-1].data;
  // Capture the request; without rotate support an enabled ROR is squashed to zero at entry
  always_comb begin
    in_st = '{vld: in_valid, en: in_en, mode: in_mode, amt: in_amt, data: in_data};
    in_st.data = (SQUASH_ROR && in_mode == 2'b11 && in_en) ? '0 : in_data;
  end
  // Stage k shifts by 2^k when its amount bit is set; every stage moves together or holds
  always_comb begin
    cur = in_st;
    for (int k = 0; k < SHW; k++) begin
      st_d[k] = cur;
      if (cur.en && cur.amt[k]) st_d[k].data = shift_by(cur.data, cur.mode, 1 << k);
      if (!advance) st_d[k] = st_q[k];
      cur = st_q[k];
    end
  end
  // Pipeline registers, all cleared by reset so in-flight work is discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= '{default: '0};
    else st_q <= st_d;
  end
endmodule
